// File: rtl/dtc_phase_scan.sv
// MMCM dynamic phase-shift controller: manual stepping, or a full-rotation eye scan that parks at the widest window's centre.
// One psen in flight at a time; each step waits for psdone, bounded by DONE_TMO, before issuing the next.
module dtc_phase_scan #(
  parameter int unsigned SCAN_STEPS = 1120,
  parameter logic [15:0] PATTERN    = 16'hA5C3,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned SAMPLE_CYC = 64,
  parameter int unsigned DONE_TMO   = 1023
) (
  input  logic        psclk_i,
  input  logic        reset_i,
  input  logic        pscmd_i,
  input  logic        psmode_i,
  input  logic [15:0] psstep_i,
  input  logic [15:0] deser_dout_i,
  input  logic        psdone_i,
  output logic        psen_o,
  output logic        psincdec_o,
  output logic        psscan_flag_o,
  output logic        scan_done_o,
  output logic        ps_err_o,
  output logic [15:0] dtcref_phase_o,
  output logic [15:0] best_phase_o,
  output logic [15:0] eye_width_o
);
  localparam logic [15:0] STEPS     = 16'(SCAN_STEPS);
  localparam logic [15:0] SETTLE_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] SAMPLE_LD = 16'(SAMPLE_CYC - 1);
  localparam logic [15:0] TMO_LD    = 16'(DONE_TMO);

  typedef enum logic [2:0] {IDLE, STEP, WAITD, SETTLE, SAMPLE, EVAL, PARK, FIN} state_t;

  state_t      state_q, state_d;
  logic        scan_q, scan_d;
  logic        pass_q, pass_d;
  logic        err_q, err_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pos_q, pos_d;
  logic [15:0] run_len_q, run_len_d;
  logic [15:0] run_start_q, run_start_d;
  logic [15:0] best_len_q, best_len_d;
  logic [15:0] best_start_q, best_start_d;
  logic [15:0] phase_q, phase_d;
  logic [15:0] best_phase_q, best_phase_d;
  logic [15:0] eye_q, eye_d;

  // Run-length bookkeeping as it would stand after evaluating the current position.
  logic [15:0] phase_inc, run_len_n, run_start_n, best_len_n, best_start_n, centre, park_cnt;
  logic [16:0] centre_sum;

  always_comb begin
    phase_inc    = (phase_q == STEPS - 16'd1) ? 16'd0 : phase_q + 16'd1;
    run_len_n    = pass_q ? run_len_q + 16'd1 : 16'd0;
    run_start_n  = (pass_q && run_len_q == 16'd0) ? phase_q : run_start_q;
    best_len_n   = (run_len_n > best_len_q) ? run_len_n : best_len_q;
    best_start_n = (run_len_n > best_len_q) ? run_start_n : best_start_q;
    centre_sum   = {1'b0, best_start_n} + {2'b00, best_len_n[15:1]};
    centre       = (centre_sum >= {1'b0, STEPS}) ? 16'(centre_sum - {1'b0, STEPS}) : centre_sum[15:0];
    park_cnt     = (centre >= phase_q) ? centre - phase_q : centre + STEPS - phase_q;
  end

  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    pass_d       = pass_q;
    err_d        = err_q;
    remain_d     = remain_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    pos_d        = pos_q;
    run_len_d    = run_len_q;
    run_start_d  = run_start_q;
    best_len_d   = best_len_q;
    best_start_d = best_start_q;
    phase_d      = phase_q;
    best_phase_d = best_phase_q;
    eye_d        = eye_q;
    psen_o       = 1'b0;
    case (state_q)
      IDLE: begin
        if (pscmd_i) begin
          scan_d       = psmode_i;
          remain_d     = psstep_i;
          err_d        = 1'b0;
          pos_d        = 16'd0;
          run_len_d    = 16'd0;
          run_start_d  = 16'd0;
          best_len_d   = 16'd0;
          best_start_d = 16'd0;
          state_d      = STEP;
        end
      end
      STEP: begin
        if (!scan_q && remain_q == 16'd0) begin
          state_d = FIN;
        end else begin
          psen_o  = 1'b1;
          tmo_d   = TMO_LD;
          state_d = WAITD;
        end
      end
      WAITD: begin
        if (psdone_i) begin
          phase_d = phase_inc;
          if (scan_q) begin
            cnt_d   = SETTLE_LD;
            state_d = SETTLE;
          end else begin
            remain_d = remain_q - 16'd1;
            state_d  = (remain_q == 16'd1) ? FIN : STEP;
          end
        end else if (tmo_q <= 16'd1) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      SETTLE: begin
        if (cnt_q == 16'd0) begin
          cnt_d   = SAMPLE_LD;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      SAMPLE: begin
        if (deser_dout_i != PATTERN) begin
          pass_d  = 1'b0;
          state_d = EVAL;
        end else if (cnt_q == 16'd0) begin
          pass_d  = 1'b1;
          state_d = EVAL;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      EVAL: begin
        run_len_d    = run_len_n;
        run_start_d  = run_start_n;
        best_len_d   = best_len_n;
        best_start_d = best_start_n;
        pos_d        = pos_q + 16'd1;
        state_d      = STEP;
        // Full rotation done: the phase is back where the scan started.
        if (pos_q + 16'd1 == STEPS) begin
          eye_d = best_len_n;
          if (best_len_n == 16'd0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            best_phase_d = centre;
            remain_d     = park_cnt;
            scan_d       = 1'b0;
            state_d      = PARK;
          end
        end
      end
      PARK:    state_d = (remain_q == 16'd0) ? FIN : STEP;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge psclk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      scan_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= 1'b0;
      remain_q     <= 16'd0;
      tmo_q        <= 16'd0;
      cnt_q        <= 16'd0;
      pos_q        <= 16'd0;
      run_len_q    <= 16'd0;
      run_start_q  <= 16'd0;
      best_len_q   <= 16'd0;
      best_start_q <= 16'd0;
      phase_q      <= 16'd0;
      best_phase_q <= 16'd0;
      eye_q        <= 16'd0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      remain_q     <= remain_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
      pos_q        <= pos_d;
      run_len_q    <= run_len_d;
      run_start_q  <= run_start_d;
      best_len_q   <= best_len_d;
      best_start_q <= best_start_d;
      phase_q      <= phase_d;
      best_phase_q <= best_phase_d;
      eye_q        <= eye_d;
    end
  end

  assign psincdec_o     = 1'b1;
  assign psscan_flag_o  = (state_q != IDLE) && (state_q != FIN);
  assign scan_done_o    = (state_q == FIN);
  assign ps_err_o       = err_q;
  assign dtcref_phase_o = phase_q;
  assign best_phase_o   = best_phase_q;
  assign eye_width_o    = eye_q;

endmodule

// File: tb/tb_dtc_phase_scan.sv
// Bench for dtc_phase_scan: behavioural MMCM/deserializer model plus a queue of expected command outcomes.
`timescale 1ns/1ps
module tb_dtc_phase_scan;
  localparam int STEPS = 1120;
  localparam logic [15:0] PAT = 16'hA5C3;
  localparam int TMO = 1023;

  typedef struct { bit done; bit err; int phase; int best; int eye; int npsen; } exp_t;

  logic clk = 1'b0, rst = 1'b1, pscmd = 1'b0, psmode = 1'b0, psdone = 1'b0;
  logic [15:0] psstep = 16'd0, deser = 16'd0;
  logic psen, psincdec, flag, done, err;
  logic [15:0] phase, best, eye;

  int checks = 0, errors = 0;
  exp_t sb[$];
  int m_best = 0, m_eye = 0;

  // MMCM / training-source model state
  int done_lat = 1, pend = 0, mphase = 0, psen_cnt = 0, overlap = 0, cyc = 0;
  int stray_req = 0, stray_ack = 0;
  bit hold_done = 1'b0;
  int win_lo[$], win_hi[$], flaky[$];

  dtc_phase_scan #(.SCAN_STEPS(STEPS), .PATTERN(PAT), .SETTLE_CYC(2), .SAMPLE_CYC(4), .DONE_TMO(TMO)) dut (
    .psclk_i(clk), .reset_i(rst), .pscmd_i(pscmd), .psmode_i(psmode), .psstep_i(psstep),
    .deser_dout_i(deser), .psdone_i(psdone), .psen_o(psen), .psincdec_o(psincdec),
    .psscan_flag_o(flag), .scan_done_o(done), .ps_err_o(err), .dtcref_phase_o(phase),
    .best_phase_o(best), .eye_width_o(eye));

  always #5 clk = ~clk;

  function automatic logic [15:0] pattern_at(int p, int c);
    foreach (flaky[i]) if (flaky[i] == p) return (c % 3 == 0) ? ~PAT : PAT;
    foreach (win_lo[i]) if (p >= win_lo[i] && p <= win_hi[i]) return PAT;
    return ~PAT ^ 16'(p);
  endfunction

  function automatic exp_t mk(bit d, bit e, int p, int b, int w, int n);
    exp_t r;
    r.done = d; r.err = e; r.phase = p; r.best = b; r.eye = w; r.npsen = n;
    return r;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      psdone = 1'b0;
      if (rst) begin
        pend = 0; mphase = 0;
      end else begin
        if (psen) begin
          psen_cnt++;
          if (pend != 0) overlap++;
          if (!hold_done) pend = done_lat;
        end else if (pend > 0) begin
          pend--;
          if (pend == 0) begin psdone = 1'b1; mphase = (mphase + 1) % STEPS; end
        end
        if (stray_req != stray_ack) begin psdone = 1'b1; stray_ack = stray_req; end
      end
      deser = pattern_at(mphase, cyc);
    end
  end

  task automatic reset_dut();
    rst = 1'b1; pscmd = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0; m_best = 0; m_eye = 0;
    @(negedge clk);
  endtask

  task automatic pulse_cmd(input bit mode, input logic [15:0] step);
    @(negedge clk);
    pscmd = 1'b1; psmode = mode; psstep = step;
    @(negedge clk);
    pscmd = 1'b0;
  endtask

  task automatic run_cmd(input bit mode, input logic [15:0] step, input int budget, input int extra_at,
                         output bit got_done, output int lat, output bit err_c1);
    pulse_cmd(mode, step);
    lat = 1; got_done = 1'b0; err_c1 = err;
    while (lat <= budget) begin
      if (extra_at == lat) begin pscmd = 1'b1; psmode = 1'b1; psstep = 16'd7; end
      else pscmd = 1'b0;
      if (done) begin got_done = 1'b1; break; end
      if (!flag) break;
      @(negedge clk);
      lat++;
    end
    pscmd = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({psen, psincdec, flag, done, err} !== 5'b01000) begin errors++;
      $display("FAIL reset_ctl: got %b want 01000", {psen, psincdec, flag, done, err}); end
    checks++; if ({phase, best, eye} !== 48'd0) begin errors++;
      $display("FAIL reset_regs: got phase %0d best %0d eye %0d want 0", phase, best, eye); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_manual();
    exp_t e; bit d, e1; int lat, p0;
    done_lat = 3; p0 = psen_cnt;
    sb.push_back(mk(1'b1, 1'b0, (mphase + 5) % STEPS, m_best, m_eye, 5));
    run_cmd(1'b0, 16'd5, 200, 0, d, lat, e1);
    e = sb.pop_front();
    checks++; if (d !== e.done || lat > 200) begin errors++; $display("FAIL manual_done: got %0b lat %0d want %0b", d, lat, e.done); end
    checks++; if (phase !== 16'(e.phase)) begin errors++; $display("FAIL manual_phase: got %0d want %0d", phase, e.phase); end
    checks++; if (psen_cnt - p0 != e.npsen) begin errors++; $display("FAIL manual_psen: got %0d want %0d", psen_cnt - p0, e.npsen); end
    checks++; if (err !== e.err) begin errors++; $display("FAIL manual_err: got %0b want %0b", err, e.err); end
    done_lat = 1;
  endtask

  task automatic test_zero_step();
    exp_t e; bit d, e1; int lat, p0;
    p0 = psen_cnt;
    sb.push_back(mk(1'b1, 1'b0, mphase, m_best, m_eye, 0));
    run_cmd(1'b0, 16'd0, 20, 0, d, lat, e1);
    e = sb.pop_front();
    checks++; if (d !== e.done || lat != 2) begin errors++; $display("FAIL zero_done: got %0b at %0d want %0b at 2", d, lat, e.done); end
    checks++; if (phase !== 16'(e.phase)) begin errors++; $display("FAIL zero_phase: got %0d want %0d", phase, e.phase); end
    checks++; if (psen_cnt - p0 != e.npsen) begin errors++; $display("FAIL zero_psen: got %0d want %0d", psen_cnt - p0, e.npsen); end
  endtask

  task automatic test_timeout();
    exp_t e; bit d, e1; int lat, p0;
    hold_done = 1'b1; p0 = psen_cnt;
    sb.push_back(mk(1'b0, 1'b1, mphase, m_best, m_eye, 1));
    run_cmd(1'b0, 16'd3, TMO + 20, 0, d, lat, e1);
    hold_done = 1'b0;
    e = sb.pop_front();
    checks++; if (lat < TMO + 1 || lat > TMO + 3) begin errors++; $display("FAIL tmo_time: got %0d want %0d..%0d", lat, TMO + 1, TMO + 3); end
    checks++; if (d !== e.done || err !== e.err || flag !== 1'b0) begin errors++;
      $display("FAIL tmo_flags: got done %0b err %0b busy %0b want %0b %0b 0", d, err, flag, e.done, e.err); end
    checks++; if (psen_cnt - p0 != e.npsen || phase !== 16'(e.phase)) begin errors++;
      $display("FAIL tmo_psen: got %0d psen phase %0d want %0d, %0d", psen_cnt - p0, phase, e.npsen, e.phase); end
    stray_req++;
    repeat (3) @(negedge clk);
    checks++; if (phase !== 16'(e.phase) || flag !== 1'b0) begin errors++;
      $display("FAIL stray_done: got phase %0d busy %0b want %0d 0", phase, flag, e.phase); end
    sb.push_back(mk(1'b1, 1'b0, (mphase + 1) % STEPS, m_best, m_eye, 1));
    run_cmd(1'b0, 16'd1, 100, 0, d, lat, e1);
    e = sb.pop_front();
    checks++; if (e1 !== 1'b0) begin errors++; $display("FAIL err_clear: got %0b want 0", e1); end
    checks++; if (d !== e.done || phase !== 16'(e.phase)) begin errors++;
      $display("FAIL tmo_recover: got done %0b phase %0d want %0b %0d", d, phase, e.done, e.phase); end
  endtask

  task automatic check_scan(input string nm, input int budget);
    exp_t e; bit d, e1; int lat, p0;
    p0 = psen_cnt;
    run_cmd(1'b1, 16'd0, budget, 0, d, lat, e1);
    e = sb.pop_front();
    checks++; if (d !== e.done || err !== e.err || lat > budget) begin errors++;
      $display("FAIL %s_status: got done %0b err %0b lat %0d want %0b %0b", nm, d, err, lat, e.done, e.err); end
    checks++; if (best !== 16'(e.best) || eye !== 16'(e.eye)) begin errors++;
      $display("FAIL %s_eye: got best %0d width %0d want %0d %0d", nm, best, eye, e.best, e.eye); end
    checks++; if (phase !== 16'(e.phase)) begin errors++; $display("FAIL %s_phase: got %0d want %0d", nm, phase, e.phase); end
    checks++; if (psen_cnt - p0 != e.npsen) begin errors++; $display("FAIL %s_psen: got %0d want %0d", nm, psen_cnt - p0, e.npsen); end
  endtask

  task automatic test_scan_single();
    reset_dut();
    win_lo = '{300}; win_hi = '{399}; flaky = '{299, 400};
    sb.push_back(mk(1'b1, 1'b0, 350, 350, 100, STEPS + 350));
    check_scan("scan1", 20000);
    m_best = 350; m_eye = 100;
  endtask

  task automatic test_scan_tie();
    reset_dut();
    win_lo = '{100, 600}; win_hi = '{149, 649}; flaky = '{};
    sb.push_back(mk(1'b1, 1'b0, 125, 125, 50, STEPS + 125));
    check_scan("tie", 20000);
    m_best = 125; m_eye = 50;
  endtask

  task automatic test_scan_fail();
    win_lo = '{}; win_hi = '{};
    sb.push_back(mk(1'b0, 1'b1, mphase, m_best, 0, STEPS));
    check_scan("nopass", 20000);
    m_eye = 0;
  endtask

  task automatic test_back_to_back();
    exp_t e; bit d, e1; int lat, p0;
    reset_dut();
    p0 = psen_cnt;
    sb.push_back(mk(1'b1, 1'b0, 1119, 0, 0, 1119));
    run_cmd(1'b0, 16'd1119, 4000, 5, d, lat, e1);
    e = sb.pop_front();
    checks++; if (d !== e.done || phase !== 16'(e.phase) || psen_cnt - p0 != e.npsen) begin errors++;
      $display("FAIL busy_cmd: got done %0b phase %0d psen %0d want %0b %0d %0d", d, phase, psen_cnt - p0, e.done, e.phase, e.npsen); end
    sb.push_back(mk(1'b1, 1'b0, 0, 0, 0, 1));
    run_cmd(1'b0, 16'd1, 100, 0, d, lat, e1);
    e = sb.pop_front();
    checks++; if (d !== e.done || phase !== 16'(e.phase)) begin errors++;
      $display("FAIL wrap: got done %0b phase %0d want %0b %0d", d, phase, e.done, e.phase); end
    win_lo = '{10}; win_hi = '{20};
    pulse_cmd(1'b1, 16'd0);
    repeat (40) @(negedge clk);
    checks++; if (flag !== 1'b1) begin errors++; $display("FAIL scan_busy: got %0b want 1", flag); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({psen, psincdec, flag, done, err} !== 5'b01000 || {phase, best, eye} !== 48'd0) begin errors++;
      $display("FAIL async_reset: got ctl %b phase %0d best %0d eye %0d want 01000 0 0 0", {psen, psincdec, flag, done, err}, phase, best, eye); end
    p0 = psen_cnt;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (psen_cnt != p0 || flag !== 1'b0) begin errors++;
      $display("FAIL post_reset: got psen %0d busy %0b want 0 0", psen_cnt - p0, flag); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL psen_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_manual();
    test_zero_step();
    test_timeout();
    test_scan_single();
    test_scan_tie();
    test_scan_fail();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
